// File: rtl/fixed_linear_seq_pkg.sv
// Shared types and width helpers for the fixed linear tile sequencer.
// Imported by the counter and the top level.
package fixed_linear_seq_pkg;

  typedef enum logic {SEQ_LOAD, SEQ_REPLAY} seq_state_t;

  // Width of a counter that spans 0..n-1; never narrower than one bit.
  function automatic int unsigned seq_cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned seq_addr_width(input int unsigned depth,
                                                 input int unsigned blocks);
    int unsigned w;
    w = $clog2(depth * blocks);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MAX up-counter: counts 0..MAX-1 on en and flags the wrapping increment.
// The wrap flag is combinational so a downstream counter can chain off it.
module wrap_counter
  import fixed_linear_seq_pkg::*;
#(
  parameter int unsigned MAX   = 4,
  parameter int unsigned WIDTH = seq_cnt_width(MAX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    wrap    = en && (count_q == WIDTH'(MAX - 1));
    count_d = count_q;
    if (wrap) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fixed_linear_tile_sequencer.sv
// Buffers one IN_DEPTH-beat activation vector, then replays it OUT_BLOCKS times,
// tagging each beat with its weight-tile address for a shared PARALLELISM-wide datapath.
module fixed_linear_tile_sequencer
  import fixed_linear_seq_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = 32,
  parameter int unsigned IN_SIZE    = 4,
  parameter int unsigned IN_DEPTH   = 3,
  parameter int unsigned OUT_BLOCKS = 2,
  parameter int unsigned ADDR_WIDTH = seq_addr_width(IN_DEPTH, OUT_BLOCKS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [IN_SIZE-1:0][IN_WIDTH-1:0]  data_in,
  input  logic                              data_in_valid,
  output logic                              data_in_ready,
  output logic [IN_SIZE-1:0][IN_WIDTH-1:0]  lin_data,
  output logic [ADDR_WIDTH-1:0]             lin_weight_addr,
  output logic                              lin_valid,
  input  logic                              lin_ready,
  output logic                              lin_block_last,
  output logic                              frame_done
);

  localparam int unsigned DW = seq_cnt_width(IN_DEPTH);
  localparam int unsigned BW = seq_cnt_width(OUT_BLOCKS);

  typedef logic [IN_SIZE-1:0][IN_WIDTH-1:0] beat_t;

  seq_state_t    state_q, state_d;
  logic [DW-1:0] depth_cnt;
  logic [BW-1:0] block_cnt;
  logic          depth_wrap, block_wrap;
  logic          in_fire, out_fire, depth_en, block_en;
  logic          frame_done_q, frame_done_d;
  beat_t         buf_q [IN_DEPTH];
  beat_t         buf_d [IN_DEPTH];
  beat_t         rd_beat;

  assign in_fire  = data_in_valid & data_in_ready;
  assign out_fire = lin_valid & lin_ready;
  // One depth counter serves both load and replay; the two fires are mutually exclusive.
  assign depth_en = in_fire | out_fire;
  assign block_en = out_fire & depth_wrap;

  wrap_counter #(
    .MAX   (IN_DEPTH),
    .WIDTH (DW)
  ) u_depth_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (depth_en),
    .count (depth_cnt),
    .wrap  (depth_wrap)
  );

  wrap_counter #(
    .MAX   (OUT_BLOCKS),
    .WIDTH (BW)
  ) u_block_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (block_en),
    .count (block_cnt),
    .wrap  (block_wrap)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SEQ_LOAD;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    frame_done_d = block_wrap;
    unique case (state_q)
      SEQ_LOAD:   if (in_fire && depth_wrap) state_d = SEQ_REPLAY;
      SEQ_REPLAY: if (block_wrap)            state_d = SEQ_LOAD;
    endcase
  end

  // Output logic
  always_comb begin
    data_in_ready   = (state_q == SEQ_LOAD);
    lin_valid       = (state_q == SEQ_REPLAY);
    lin_data        = lin_valid ? rd_beat : '0;
    lin_weight_addr = '0;
    if (lin_valid) begin
      lin_weight_addr = ADDR_WIDTH'(block_cnt) * ADDR_WIDTH'(IN_DEPTH) + ADDR_WIDTH'(depth_cnt);
    end
    lin_block_last  = lin_valid && (depth_cnt == DW'(IN_DEPTH - 1));
  end

  assign frame_done = frame_done_q;

  // Decoded write/read avoids indexing the buffer with a counter wider than its range.
  always_comb begin
    rd_beat = '0;
    for (int unsigned i = 0; i < IN_DEPTH; i++) begin
      buf_d[i] = buf_q[i];
      if (in_fire && (depth_cnt == DW'(i))) buf_d[i] = data_in;
      if (depth_cnt == DW'(i))              rd_beat  = buf_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < IN_DEPTH; i++) buf_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < IN_DEPTH; i++) buf_q[i] <= buf_d[i];
    end
  end

endmodule

// File: tb/tb_fixed_linear_tile_sequencer.sv
// Directed bench for fixed_linear_tile_sequencer: default 3x2 configuration plus a
// 1x1 instance. Inputs change on the falling edge, outputs are sampled there too.
module tb_fixed_linear_tile_sequencer;

  typedef logic [3:0][31:0] vec_t;

  logic       clk = 1'b0;
  logic       rst;
  vec_t       data_in, lin_data;
  logic       data_in_valid, data_in_ready, lin_valid, lin_ready, lin_block_last, frame_done;
  logic [2:0] lin_weight_addr;

  vec_t       s_data_in, s_lin_data;
  logic       s_valid, s_ready, s_lin_valid, s_lin_ready, s_block_last, s_frame_done;
  logic [0:0] s_addr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fixed_linear_tile_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .data_in         (data_in),
    .data_in_valid   (data_in_valid),
    .data_in_ready   (data_in_ready),
    .lin_data        (lin_data),
    .lin_weight_addr (lin_weight_addr),
    .lin_valid       (lin_valid),
    .lin_ready       (lin_ready),
    .lin_block_last  (lin_block_last),
    .frame_done      (frame_done)
  );

  fixed_linear_tile_sequencer #(
    .IN_DEPTH   (1),
    .OUT_BLOCKS (1)
  ) dut_small (
    .clk             (clk),
    .rst             (rst),
    .data_in         (s_data_in),
    .data_in_valid   (s_valid),
    .data_in_ready   (s_ready),
    .lin_data        (s_lin_data),
    .lin_weight_addr (s_addr),
    .lin_valid       (s_lin_valid),
    .lin_ready       (s_lin_ready),
    .lin_block_last  (s_block_last),
    .frame_done      (s_frame_done)
  );

  // Observations gathered by capture()
  vec_t       cap_d [6];
  logic [2:0] cap_a [6];
  logic       cap_bl[6];
  int         nfire, first_fire, last_fire, done_cnt, done_cyc, rdy_err, hold_err;
  logic       post_valid, post_ready;
  vec_t       ev[3];

  function automatic vec_t mk(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  task automatic send_beat(input vec_t v, input int gap, output bit saw_done, output bit tmo);
    int waited;
    repeat (gap) begin
      @(negedge clk);
      data_in_valid = 1'b0;
      data_in       = mk(32'hdead, 32'hbeef, 32'hdead, 32'hbeef);
    end
    @(negedge clk);
    data_in_valid = 1'b1;
    data_in       = v;
    waited        = 0;
    tmo           = 1'b0;
    while (!data_in_ready) begin
      if (waited >= 60) begin
        tmo = 1'b1;
        break;
      end
      @(negedge clk);
      waited++;
    end
    saw_done = frame_done;
    @(posedge clk);
    #1 data_in_valid = 1'b0;
  endtask

  task automatic load_frame(input int gap, output int tmo_cnt);
    bit sd, t;
    tmo_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      send_beat(ev[i], gap, sd, t);
      if (t) tmo_cnt++;
    end
  endtask

  task automatic capture(input bit stall);
    bit         prev_stall;
    vec_t       prev_d;
    logic [2:0] prev_a;
    nfire = 0; first_fire = -1; last_fire = -100; done_cnt = 0; done_cyc = -1;
    rdy_err = 0; hold_err = 0; prev_stall = 1'b0; post_valid = 1'bx; post_ready = 1'bx;
    prev_d = '0; prev_a = '0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (nfire == 6 && cyc == last_fire + 1) begin
        post_valid = lin_valid;
        post_ready = data_in_ready;
      end
      if (prev_stall && (!lin_valid || lin_data !== prev_d || lin_weight_addr !== prev_a))
        hold_err++;
      if (lin_valid && data_in_ready) rdy_err++;
      lin_ready = stall ? (cyc % 3 == 0) : 1'b1;
      if (lin_valid && lin_ready) begin
        if (nfire < 6) begin
          cap_d[nfire]  = lin_data;
          cap_a[nfire]  = lin_weight_addr;
          cap_bl[nfire] = lin_block_last;
        end
        if (first_fire < 0) first_fire = cyc;
        last_fire = cyc;
        nfire++;
      end
      prev_stall = lin_valid && !lin_ready;
      prev_d     = lin_data;
      prev_a     = lin_weight_addr;
      if (nfire >= 6 && cyc >= last_fire + 3) break;
    end
    lin_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    data_in_valid = 1'b0; data_in = '0; lin_ready = 1'b0;
    s_valid = 1'b0; s_data_in = '0; s_lin_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (data_in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", data_in_ready); end
    tests++; if (lin_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", lin_valid); end
    tests++; if (lin_data !== '0) begin fails++; $display("FAIL reset_data: got %h want 0", lin_data); end
    tests++; if (lin_weight_addr !== 3'd0) begin fails++; $display("FAIL reset_addr: got %0d want 0", lin_weight_addr); end
    tests++; if (lin_block_last !== 1'b0) begin fails++; $display("FAIL reset_last: got %b want 0", lin_block_last); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", frame_done); end
    tests++; if (s_lin_valid !== 1'b0 || s_block_last !== 1'b0) begin fails++; $display("FAIL reset_small: valid %b last %b want 0 0", s_lin_valid, s_block_last); end
  endtask

  task automatic test_basic();
    int t;
    ev[0] = mk(1, 2, 3, 4); ev[1] = mk(5, 6, 7, 8); ev[2] = mk(9, 10, 11, 12);
    load_frame(0, t);
    capture(1'b0);
    tests++; if (t !== 0) begin fails++; $display("FAIL basic_load_timeout: got %0d want 0", t); end
    tests++; if (first_fire !== 0) begin fails++; $display("FAIL basic_latency: got %0d want 0", first_fire); end
    tests++; if (nfire !== 6) begin fails++; $display("FAIL basic_fires: got %0d want 6", nfire); end
    for (int i = 0; i < 6; i++) begin
      tests++; if (cap_d[i] !== ev[i % 3]) begin fails++; $display("FAIL basic_data[%0d]: got %h want %h", i, cap_d[i], ev[i % 3]); end
      tests++; if (cap_a[i] !== 3'(i)) begin fails++; $display("FAIL basic_addr[%0d]: got %0d want %0d", i, cap_a[i], i); end
      tests++; if (cap_bl[i] !== (i % 3 == 2)) begin fails++; $display("FAIL basic_last[%0d]: got %b want %b", i, cap_bl[i], (i % 3 == 2)); end
    end
    tests++; if (last_fire - first_fire !== 5) begin fails++; $display("FAIL basic_throughput: got %0d want 5", last_fire - first_fire); end
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
    tests++; if (done_cyc !== last_fire + 1) begin fails++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, last_fire + 1); end
    tests++; if (rdy_err !== 0) begin fails++; $display("FAIL basic_ready_in_replay: got %0d want 0", rdy_err); end
    tests++; if (post_valid !== 1'b0 || post_ready !== 1'b1) begin fails++; $display("FAIL basic_back_to_load: valid %b ready %b want 0 1", post_valid, post_ready); end
  endtask

  task automatic test_backpressure();
    int t;
    ev[0] = mk(32'h101, 32'h102, 32'h103, 32'h104);
    ev[1] = mk(32'h201, 32'h202, 32'h203, 32'h204);
    ev[2] = mk(32'h301, 32'h302, 32'h303, 32'h304);
    load_frame(0, t);
    capture(1'b1);
    tests++; if (nfire !== 6) begin fails++; $display("FAIL bp_fires: got %0d want 6", nfire); end
    tests++; if (hold_err !== 0) begin fails++; $display("FAIL bp_hold: got %0d want 0", hold_err); end
    tests++; if (last_fire !== 15) begin fails++; $display("FAIL bp_last_cycle: got %0d want 15", last_fire); end
    for (int i = 0; i < 6; i++) begin
      tests++; if (cap_d[i] !== ev[i % 3] || cap_a[i] !== 3'(i)) begin fails++; $display("FAIL bp_beat[%0d]: got %h/%0d want %h/%0d", i, cap_d[i], cap_a[i], ev[i % 3], i); end
    end
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_upstream_gaps();
    bit sd, t0, t1, t2;
    ev[0] = mk(32'haa0, 32'haa1, 32'haa2, 32'haa3);
    ev[1] = mk(32'hbb0, 32'hbb1, 32'hbb2, 32'hbb3);
    ev[2] = mk(32'hcc0, 32'hcc1, 32'hcc2, 32'hcc3);
    send_beat(ev[0], 2, sd, t0);
    send_beat(ev[1], 2, sd, t1);
    @(negedge clk);
    tests++; if (lin_valid !== 1'b0 || data_in_ready !== 1'b1) begin fails++; $display("FAIL gap_still_loading: valid %b ready %b want 0 1", lin_valid, data_in_ready); end
    send_beat(ev[2], 1, sd, t2);
    capture(1'b0);
    tests++; if ({t0, t1, t2} !== 3'b000) begin fails++; $display("FAIL gap_timeout: got %b want 000", {t0, t1, t2}); end
    tests++; if (first_fire !== 0) begin fails++; $display("FAIL gap_latency: got %0d want 0", first_fire); end
    tests++; if (nfire !== 6) begin fails++; $display("FAIL gap_fires: got %0d want 6", nfire); end
    for (int i = 0; i < 6; i++) begin
      tests++; if (cap_d[i] !== ev[i % 3] || cap_a[i] !== 3'(i)) begin fails++; $display("FAIL gap_beat[%0d]: got %h/%0d want %h/%0d", i, cap_d[i], cap_a[i], ev[i % 3], i); end
    end
  endtask

  task automatic test_back_to_back();
    int   t, a_fires;
    bit   sd0, sd, tb0, tb1, tb2;
    vec_t bv[3];
    ev[0] = mk(21, 22, 23, 24); ev[1] = mk(25, 26, 27, 28); ev[2] = mk(29, 30, 31, 32);
    bv[0] = mk(41, 42, 43, 44); bv[1] = mk(45, 46, 47, 48); bv[2] = mk(49, 50, 51, 52);
    load_frame(0, t);
    fork
      capture(1'b0);
      begin
        send_beat(bv[0], 0, sd0, tb0);
        send_beat(bv[1], 0, sd, tb1);
        send_beat(bv[2], 0, sd, tb2);
      end
    join
    a_fires = nfire;
    tests++; if (a_fires !== 6 || rdy_err !== 0) begin fails++; $display("FAIL b2b_frame_a: fires %0d overlap %0d want 6 0", a_fires, rdy_err); end
    tests++; if (sd0 !== 1'b1) begin fails++; $display("FAIL b2b_accept_at_done: got %b want 1", sd0); end
    tests++; if ({tb0, tb1, tb2} !== 3'b000) begin fails++; $display("FAIL b2b_timeout: got %b want 000", {tb0, tb1, tb2}); end
    capture(1'b0);
    tests++; if (first_fire !== 0 || nfire !== 6) begin fails++; $display("FAIL b2b_frame_b: first %0d fires %0d want 0 6", first_fire, nfire); end
    for (int i = 0; i < 6; i++) begin
      tests++; if (cap_d[i] !== bv[i % 3] || cap_a[i] !== 3'(i)) begin fails++; $display("FAIL b2b_beat[%0d]: got %h/%0d want %h/%0d", i, cap_d[i], cap_a[i], bv[i % 3], i); end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    bit found;
    ev[0] = mk(61, 62, 63, 64); ev[1] = mk(65, 66, 67, 68); ev[2] = mk(69, 70, 71, 72);
    load_frame(0, t);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lin_ready = 1'b1;
      if (lin_valid && lin_weight_addr == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if (found !== 1'b1) begin fails++; $display("FAIL rst_mid_reach_addr3: got %b want 1", found); end
    tests++; if (lin_valid !== 1'b0 || data_in_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_state: valid %b ready %b want 0 1", lin_valid, data_in_ready); end
    tests++; if (lin_weight_addr !== 3'd0 || frame_done !== 1'b0) begin fails++; $display("FAIL rst_mid_outputs: addr %0d done %b want 0 0", lin_weight_addr, frame_done); end
    @(negedge clk);
    rst = 1'b0;
    lin_ready = 1'b0;
    ev[0] = mk(81, 82, 83, 84); ev[1] = mk(85, 86, 87, 88); ev[2] = mk(89, 90, 91, 92);
    load_frame(0, t);
    capture(1'b0);
    tests++; if (nfire !== 6 || done_cnt !== 1) begin fails++; $display("FAIL rst_mid_next_frame: fires %0d done %0d want 6 1", nfire, done_cnt); end
    for (int i = 0; i < 6; i++) begin
      tests++; if (cap_d[i] !== ev[i % 3] || cap_a[i] !== 3'(i)) begin fails++; $display("FAIL rst_mid_beat[%0d]: got %h/%0d want %h/%0d", i, cap_d[i], cap_a[i], ev[i % 3], i); end
    end
  endtask

  task automatic test_depth1();
    vec_t v;
    v = mk(32'h11, 32'h22, 32'h33, 32'h44);
    @(negedge clk);
    s_valid   = 1'b1;
    s_data_in = v;
    @(posedge clk);
    #1 s_valid = 1'b0;
    @(negedge clk);
    tests++; if (s_lin_valid !== 1'b1 || s_ready !== 1'b0) begin fails++; $display("FAIL d1_replay: valid %b ready %b want 1 0", s_lin_valid, s_ready); end
    tests++; if (s_lin_data !== v || s_addr !== 1'b0) begin fails++; $display("FAIL d1_beat: got %h/%0d want %h/0", s_lin_data, s_addr, v); end
    tests++; if (s_block_last !== 1'b1) begin fails++; $display("FAIL d1_last: got %b want 1", s_block_last); end
    s_lin_ready = 1'b1;
    @(negedge clk);
    s_lin_ready = 1'b0;
    tests++; if (s_frame_done !== 1'b1 || s_lin_valid !== 1'b0 || s_ready !== 1'b1) begin fails++; $display("FAIL d1_done: done %b valid %b ready %b want 1 0 1", s_frame_done, s_lin_valid, s_ready); end
    @(negedge clk);
    tests++; if (s_frame_done !== 1'b0) begin fails++; $display("FAIL d1_done_pulse: got %b want 0", s_frame_done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_upstream_gaps();
    test_back_to_back();
    test_reset_mid();
    test_depth1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end

endmodule
